comp_sume3: RTL and testbench
=============================

// Module: comp_sume3
//
// PURPOSE
//  Add-3 correction cell ("suma 3") for shift-and-add-3 (double-dabble) binary-to-BCD
//  conversion in the ASCII adder datapath.
//  Takes one 4-bit digit on four scalar inputs (inA = MSB) and outputs the digit plus 3
//  when it is >= 5, else unchanged. Output is registered on clk.
//  Chained instances form the BCD converter that feeds ASCII encoding.
//
// PARAMETERS
//  REG_OUT   1   1: S registered (1-cycle latency, rst honoured); 0: S purely combinational, clk/rst unused
//
// PORTS
//  clk   in   1   system clock, rising-edge active
//  rst   in   1   synchronous reset, active-high
//  inA   in   1   digit bit 3 (MSB)
//  inB   in   1   digit bit 2
//  inC   in   1   digit bit 1
//  inD   in   1   digit bit 0 (LSB)
//  S     out  4   corrected digit, S[3] = MSB
//
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (clk, rst).
//  - d = {inA,inB,inC,inD}, unsigned 0..15.
//  - f(d) = (d >= 5) ? (d + 3) mod 16 : d. Sum computed 4 bits wide; carry discarded.
//      0-4   -> unchanged (0,1,2,3,4)
//      5-9   -> 8,9,10,11,12
//      10-12 -> 13,14,15
//      13-15 -> 0,1,2 (wrap)
//  - Codes 10-15 are never produced upstream in normal double-dabble use. They are still
//    fully defined by the wrap rule above; no don't-care optimisation.
//  - REG_OUT=1:
//      - Every rising clk edge: S <= rst ? 4'd0 : f(d).
//      - Latency exactly 1 cycle; no enable, no handshake; new value accepted every cycle.
//  - Reset value of S = 0 (equals f(0), so no glitch on release).
//      - rst asserted mid-stream: S = 0 at the next edge, regardless of d.
//      - First edge after rst deasserts: S = f(d).
//      - rst and an input change in the same cycle: rst wins.
//  - REG_OUT=0: S = f(d) continuously (zero latency), rst ignored.
//  - Before the first clk edge with REG_OUT=1, S is X. Benches must reset first.
//  - No internal state beyond the S register.
//
// STRUCTURE
//  - Shared package (bcd_pkg): localparam ADD3_THRESH = 4'd5, ADD3_OFFSET = 4'd3,
//    DIGIT_W = 4. Reused by the converter top.
//  - Sub-module add3_core: combinational, 4-bit in / 4-bit out, implements f().
//    comp_sume3 = add3_core + optional output register (generate on REG_OUT).
//  - No other hierarchy.
//
// TESTING
//  1. rst=1 for 2 clocks with d=4'b1001 -> S=0 during reset.
//     Release rst -> S=12 one edge later.
//  2. Exhaustive sweep d=0..15, one per clock ->
//     S = 0,1,2,3,4,8,9,10,11,12,13,14,15,0,1,2, each lagging its input by 1 cycle.
//  3. Threshold pair d=4 then d=5 on consecutive cycles -> S=4 then S=8.
//  4. Mid-stream reset: d=7, S=10; assert rst for 1 cycle with d=7 -> S=0.
//     Deassert -> S=10 on the next edge.
//  5. Asynchronous-looking stimulus: inA/inB/inC/inD toggle every 20/40/60/80 ns
//     with a 10 ns clk -> S at every edge equals f(d) sampled at that edge
//     (scoreboard against a reference model).
//  6. REG_OUT=0 build: d=6 -> S=9 with no clock edge required; rst=1 has no effect.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and the add-3 rule for the binary-to-BCD converter datapath.
package bcd_pkg;

    localparam int unsigned     DIGIT_W     = 4;
    localparam logic [3:0]      ADD3_THRESH = 4'd5;
    localparam logic [3:0]      ADD3_OFFSET = 4'd3;

    // Double-dabble correction: add 3 to any digit >= 5, 4-bit wrap, carry dropped.
    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        r = d;
        if (d >= ADD3_THRESH) begin
            r = d + ADD3_OFFSET;
        end
        return r;
    endfunction

endpackage

// File: rtl/add3_core.sv
// Combinational add-3 correction of one 4-bit digit.
module add3_core
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] s
);

    // Apply the correction rule; codes 10-15 follow the same wrap rule.
    always_comb begin
        s = add3(d);
    end

endmodule

// File: rtl/comp_sume3.sv
// Add-3 correction cell with optional output register.
module comp_sume3
    import bcd_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inA,
    input  logic               inB,
    input  logic               inC,
    input  logic               inD,
    output logic [DIGIT_W-1:0] S
);

    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] corrected;

    assign digit = {inA, inB, inC, inD};

    add3_core u_core (
        .d (digit),
        .s (corrected)
    );

    generate
        if (REG_OUT) begin : g_reg
            // Register the corrected digit; reset value 0 equals f(0).
            always_ff @(posedge clk) begin
                if (rst) begin
                    S <= '0;
                end else begin
                    S <= corrected;
                end
            end
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign S = corrected;
        end
    endgenerate

endmodule

// File: tb/tb_comp_sume3.sv
// Directed self-checking bench for comp_sume3 (registered and combinational builds).
module tb_comp_sume3;

    logic       clk;
    logic       rst;
    logic       inA, inB, inC, inD;
    logic [3:0] s_reg;
    logic [3:0] s_comb;

    int nvec;
    int nerr;

    comp_sume3 #(.REG_OUT(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .inA (inA),
        .inB (inB),
        .inC (inC),
        .inD (inD),
        .S   (s_reg)
    );

    comp_sume3 #(.REG_OUT(1'b0)) u_comb (
        .clk (clk),
        .rst (rst),
        .inA (inA),
        .inB (inB),
        .inC (inC),
        .inD (inD),
        .S   (s_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] d);
        {inA, inB, inC, inD} = d;
    endtask

    // Drive inputs now, then check the registered output 1 ns after the next edge.
    task automatic cyc(input logic [3:0] d, input logic r, input logic [3:0] exp, input string tag);
        set_d(d);
        rst = r;
        @(posedge clk);
        #1;
        check(tag, s_reg, exp);
    endtask

    function automatic logic [3:0] ref_f(input logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

    // Hand-computed responses for d = 0..15.
    logic [3:0] sweep_exp [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10,
                                   4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        set_d(4'd9);

        // 1: reset for two edges with d=9, then release.
        cyc(4'd9, 1'b1, 4'd0, "rst_hold0");
        cyc(4'd9, 1'b1, 4'd0, "rst_hold1");
        check("comb_during_rst", s_comb, 4'd12);
        cyc(4'd9, 1'b0, 4'd12, "rst_release");

        // 2: exhaustive sweep, one digit per clock, 1-cycle latency.
        for (int unsigned i = 0; i < 16; i++) begin
            cyc(4'(i), 1'b0, sweep_exp[i], $sformatf("sweep_d%0d", i));
            check($sformatf("comb_sweep_d%0d", i), s_comb, sweep_exp[i]);
        end

        // 3: threshold pair.
        cyc(4'd4, 1'b0, 4'd4, "thresh_d4");
        cyc(4'd5, 1'b0, 4'd8, "thresh_d5");

        // 4: mid-stream reset, including rst with a simultaneous input change.
        cyc(4'd7, 1'b0, 4'd10, "mid_pre");
        cyc(4'd7, 1'b1, 4'd0,  "mid_rst");
        cyc(4'd7, 1'b0, 4'd10, "mid_release");
        cyc(4'd9, 1'b1, 4'd0,  "rst_wins_change");
        cyc(4'd9, 1'b0, 4'd12, "rst_wins_release");

        // 6: combinational build responds without an edge and ignores rst.
        @(negedge clk);
        set_d(4'd6);
        rst = 1'b1;
        #1;
        check("comb_d6_rst", s_comb, 4'd9);
        set_d(4'd13);
        #1;
        check("comb_d13_rst", s_comb, 4'd0);
        rst = 1'b0;
        #1;
        check("comb_d13", s_comb, 4'd0);

        // 5: free-running input toggles against a scoreboard at every edge.
        set_d(4'd0);
        @(posedge clk);
        #5;
        fork
            repeat (24) begin #20 inA = ~inA; end
            repeat (12) begin #40 inB = ~inB; end
            repeat (8)  begin #60 inC = ~inC; end
            repeat (6)  begin #80 inD = ~inD; end
            begin
                logic [3:0] dd;
                for (int unsigned k = 0; k < 47; k++) begin
                    @(posedge clk);
                    dd = {inA, inB, inC, inD};
                    #1;
                    check($sformatf("toggle_reg_%0d", k), s_reg, ref_f(dd));
                    check($sformatf("toggle_comb_%0d", k), s_comb, ref_f(dd));
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
